// File: rtl/popcnt_pkg.sv
// Shared types and width helpers for the round-robin ones-count scheduler.
// Used by popcnt_sched and popcnt_chunk.
package popcnt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int ones_w(input int w);
        return $clog2(w + 1);
    endfunction

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CHUNK = 4;
    localparam int ONES_W    = ones_w(DEF_WIDTH);

endpackage

// File: rtl/popcnt_chunk.sv
// Combinational ones count of one CHUNK-bit slice.
// Single shared instance sits behind the scheduler's shift register.
module popcnt_chunk
    import popcnt_pkg::*;
#(
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic [CHUNK-1:0]           bits,
    output logic [ones_w(CHUNK)-1:0]   ones
);

    localparam int CW = ones_w(CHUNK);

    always_comb begin
        ones = '0;
        for (int i = 0; i < CHUNK; i++) begin
            ones = ones + CW'(bits[i]);
        end
    end

endmodule

// File: rtl/popcnt_sched.sv
// Round-robin scheduler sharing one chunked ones-count engine among NREQ requesters.
// Define POPCNT_ZERO_SKIP_EN to leave COUNT early once the remaining word is zero.
module popcnt_sched
    import popcnt_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*WIDTH-1:0]     req_data,
    output logic [NREQ-1:0]           req_ready,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [ones_w(WIDTH)-1:0]  res_ones,
    output logic [id_w(NREQ)-1:0]     res_id,
    output logic                      busy
);

    localparam int OW    = ones_w(WIDTH);
    localparam int IW    = id_w(NREQ);
    localparam int CW    = ones_w(CHUNK);
    localparam int BEATS = WIDTH / CHUNK;
    localparam int BW    = $clog2(BEATS) + 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d, shift_nx;
    logic [OW-1:0]    acc_q, acc_d;
    logic [IW-1:0]    id_q, id_d;
    logic [IW-1:0]    rr_q, rr_d;
    logic [BW-1:0]    beat_q, beat_d;

    logic [NREQ-1:0]  gnt;
    logic [IW-1:0]    gnt_idx;
    logic             gnt_any;
    logic             last_beat;
    logic [CW-1:0]    chunk_ones;

    popcnt_chunk #(.CHUNK(CHUNK)) u_chunk (
        .bits (shift_q[CHUNK-1:0]),
        .ones (chunk_ones)
    );

    assign shift_nx = shift_q >> CHUNK;

`ifdef POPCNT_ZERO_SKIP_EN
    assign last_beat = (beat_q == BW'(BEATS - 1)) || (shift_nx == '0);
`else
    assign last_beat = (beat_q == BW'(BEATS - 1));
`endif

    // First valid requester at or above rr_q, wrapping around.
    always_comb begin
        int j;
        j       = 0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(rr_q) + k) % NREQ;
            if (!gnt_any && req_valid[IW'(j)]) begin
                gnt_any = 1'b1;
                gnt_idx = IW'(j);
            end
        end
        gnt = gnt_any ? (NREQ'(1) << gnt_idx) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            acc_q   <= '0;
            id_q    <= '0;
            rr_q    <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            acc_q   <= acc_d;
            id_q    <= id_d;
            rr_q    <= rr_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (gnt_any)   state_d = COUNT;
            COUNT:   if (last_beat) state_d = DONE;
            DONE:    if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        shift_d = shift_q;
        acc_d   = acc_q;
        id_d    = id_q;
        rr_d    = rr_q;
        beat_d  = beat_q;
        unique case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    shift_d = req_data[int'(gnt_idx)*WIDTH +: WIDTH];
                    acc_d   = '0;
                    id_d    = gnt_idx;
                    beat_d  = '0;
                    rr_d    = (gnt_idx == IW'(NREQ - 1)) ? '0
                                                         : gnt_idx + IW'(1);
                end
            end
            COUNT: begin
                acc_d   = acc_q + OW'(chunk_ones);
                shift_d = shift_nx;
                beat_d  = beat_q + BW'(1);
            end
            default: ;
        endcase
    end

    always_comb begin
        req_ready = '0;
        res_valid = 1'b0;
        busy      = 1'b1;
        unique case (state_q)
            IDLE: begin
                req_ready = gnt;
                busy      = 1'b0;
            end
            DONE:    res_valid = 1'b1;
            default: ;
        endcase
    end

    assign res_ones = acc_q;
    assign res_id   = id_q;

endmodule

// File: tb/tb_popcnt_sched.sv
// Scoreboard bench for popcnt_sched: transaction-level round-robin model,
// expected results queued at acceptance and checked by an independent monitor.
module tb_popcnt_sched;

    localparam int NREQ  = 2;
    localparam int WIDTH = 16;
    localparam int CHUNK = 4;
    localparam int BEATS = WIDTH / CHUNK;
    localparam int INF   = 1 << 30;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ*WIDTH-1:0] req_data = '0;
    logic [NREQ-1:0]       req_ready;
    logic                  res_valid;
    logic                  res_ready = 1'b0;
    logic [4:0]            res_ones;
    logic [0:0]            res_id;
    logic                  busy;

    always #5 clk = ~clk;

    popcnt_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_ones  (res_ones),
        .res_id    (res_id),
        .busy      (busy)
    );

    typedef struct {
        int ones;
        int id;
        int t;
    } exp_t;

    exp_t             q[$];
    int               n_cmp = 0;
    int               n_err = 0;
    int               cyc = 0;
    int               idle_from = 0;
    int               m_rr = 0;
    int               n_grant = 0;
    bit               pend[NREQ];
    bit               hold[NREQ];
    logic [WIDTH-1:0] word[NREQ];
    bit               rand_mode = 1'b0;
    bit               rdy_val = 1'b1;
    bit               prev_v = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int popc(input logic [WIDTH-1:0] w);
        int n = 0;
        for (int i = 0; i < WIDTH; i++) n += int'(w[i]);
        return n;
    endfunction

    function automatic int lat_beats(input logic [WIDTH-1:0] w);
`ifdef POPCNT_ZERO_SKIP_EN
        int b = 1;
        logic [WIDTH-1:0] s;
        for (int c = 0; c < BEATS; c++) begin
            s = w >> (c * CHUNK);
            if (s[CHUNK-1:0] != '0) b = c + 1;
        end
        return b;
`else
        return BEATS;
`endif
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic bit any_pend();
        bit a = 1'b0;
        for (int i = 0; i < NREQ; i++) a |= pend[i];
        return a;
    endfunction

    always @(negedge clk) begin
        #2;
        if (rst) begin
            prev_v = 1'b0;
        end else begin
            if (res_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_res_valid", int'(res_valid), 0);
                end else begin
                    chk("res_ones", int'(res_ones), q[0].ones);
                    chk("res_id", int'(res_id), q[0].id);
                    if (!prev_v) chk("latency", cyc, q[0].t);
                    if (res_ready) begin
                        void'(q.pop_front());
                        idle_from = cyc + 1;
                    end
                end
            end
            prev_v = res_valid;
        end
    end

    task automatic step();
        int          g;
        bit          idle;
        logic [NREQ-1:0] er;
        @(negedge clk);
        if (rand_mode) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    case ($urandom_range(0, 7))
                        0:       word[i] = '0;
                        1:       word[i] = '1;
                        default: word[i] = WIDTH'($urandom);
                    endcase
                end else if (pend[i] && $urandom_range(0, 15) == 0) begin
                    pend[i] = 1'b0;
                end
            end
            rdy_val = ($urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = pend[i];
            req_data[i*WIDTH +: WIDTH] = word[i];
        end
        res_ready = rdy_val;
        #1;
        idle = (cyc >= idle_from);
        g = -1;
        if (idle) begin
            for (int k = 0; k < NREQ; k++) begin
                int j;
                j = (m_rr + k) % NREQ;
                if (g < 0 && pend[j]) g = j;
            end
        end
        er = (g >= 0) ? (NREQ'(1) << g) : '0;
        chk("req_ready", int'(req_ready), int'(er));
        chk("busy", int'(busy), int'(!idle));
        if (g >= 0) begin
            q.push_back('{popc(word[g]), g, cyc + 1 + lat_beats(word[g])});
            idle_from = INF;
            m_rr = (g + 1) % NREQ;
            n_grant++;
            if (!hold[g]) pend[g] = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || any_pend()) && n < 300) begin
            step();
            n++;
        end
        chk("drain_timeout", q.size(), 0);
    endtask

    task automatic send(input int r, input logic [WIDTH-1:0] w);
        pend[r] = 1'b1;
        word[r] = w;
        drain();
    endtask

    initial begin
        int g0;
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b0;
            hold[i] = 1'b0;
            word[i] = '0;
        end
        repeat (3) @(negedge clk);
        #1;
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_res_ones", int'(res_ones), 0);
        chk("rst_res_id", int'(res_id), 0);
        @(negedge clk);
        #3 rst = 1'b0;

        rdy_val = 1'b1;
        send(0, 16'h00FA);
        send(1, 16'hFFFF);
        send(1, 16'h0000);
        send(0, 16'h000F);
        send(1, 16'hF000);

        // Both requesters hold valid: grants must alternate.
        hold[0] = 1'b1;
        hold[1] = 1'b1;
        word[0] = 16'h0001;
        word[1] = 16'h8003;
        pend[0] = 1'b1;
        pend[1] = 1'b1;
        g0 = n_grant;
        for (int n = 0; n < 200 && n_grant < g0 + 4; n++) step();
        chk("alt_grants", n_grant - g0, 4);
        hold[0] = 1'b0;
        hold[1] = 1'b0;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        drain();

        rdy_val = 1'b0;
        pend[0] = 1'b1;
        word[0] = 16'h00FA;
        repeat (9) step();
        chk("stall_valid", int'(res_valid), 1);
        chk("stall_ones", int'(res_ones), 6);
        rdy_val = 1'b1;
        drain();

        // Abort a word in its second COUNT cycle.
        pend[1] = 1'b1;
        word[1] = 16'hFFFF;
        step();
        step();
        @(negedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_res_valid", int'(res_valid), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_req_ready", int'(req_ready), 0);
        chk("arst_res_ones", int'(res_ones), 0);
        chk("arst_res_id", int'(res_id), 0);
        q.delete();
        idle_from = 0;
        m_rr = 0;
        repeat (2) step();
        @(negedge clk);
        #3 rst = 1'b0;
        pend[0] = 1'b1;
        pend[1] = 1'b1;
        word[0] = 16'h0001;
        word[1] = 16'h8003;
        drain();

        rand_mode = 1'b1;
        repeat (600) step();
        rand_mode = 1'b0;
        rdy_val = 1'b1;
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        drain();
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
